// File: rtl/reversalmb_pattern_comparator_pkg.sv
// Shared MBINIT.REVERSALMB definitions: FSM encoding, clear command and
// the per-lane-ID pattern that every lane is expected to carry.
package reversalmb_pattern_comparator_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCollect = 2'd1,
        StEval    = 2'd2,
        StDone    = 2'd3
    } rmb_state_e;

    localparam logic [1:0] CLEAR_CMD          = 2'b01;
    localparam logic [3:0] PER_LANE_ID_NIBBLE = 4'hA;

    // Lane i carries {A, i[7:0], A}; bit 15 arrives first.
    function automatic logic [15:0] lane_expected_word(input int unsigned lane);
        return {PER_LANE_ID_NIBBLE, 8'(lane), PER_LANE_ID_NIBBLE};
    endfunction

endpackage

// File: rtl/reversalmb_pattern_comparator_if.sv
// Control/data bundle between the REVERSALMB sequencer side and the comparator.
interface reversalmb_pattern_comparator_if #(
    parameter int unsigned NUM_LANES = 16
);
    logic                 i_detect_en;
    logic [1:0]           i_clear_comparator;
    logic                 i_lane_valid;
    logic [NUM_LANES-1:0] i_lane_data;
    logic [NUM_LANES-1:0] o_REVERSAL_Pattern_Result_logged;
    logic                 o_result_valid;
    logic                 o_busy;
    logic [7:0]           o_iter_count;

    modport master (
        output i_detect_en, i_clear_comparator, i_lane_valid, i_lane_data,
        input  o_REVERSAL_Pattern_Result_logged, o_result_valid, o_busy, o_iter_count
    );

    modport slave (
        input  i_detect_en, i_clear_comparator, i_lane_valid, i_lane_data,
        output o_REVERSAL_Pattern_Result_logged, o_result_valid, o_busy, o_iter_count
    );
endinterface

// File: rtl/reversalmb_lane_err_counter.sv
// One lane: deserialise MSB-first, compare each completed word against the
// lane's ID pattern and count mismatching words with saturation.
module reversalmb_lane_err_counter
    import reversalmb_pattern_comparator_pkg::*;
#(
    parameter int unsigned LANE_IDX  = 0,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 CLK,
    input  logic                 rst,
    input  logic                 i_clear,
    input  logic                 i_shift_en,
    input  logic                 i_cmp_stb,
    input  logic                 i_bit,
    output logic [ERR_CNT_W-1:0] o_err_cnt
);
    localparam logic [15:0] EXPECTED = lane_expected_word(LANE_IDX);

    logic [14:0]          r_shift;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic [15:0]          w_word;

    // The compare uses the incoming bit directly so back-to-back words need no bubble.
    assign w_word = {r_shift, i_bit};

    always_ff @(posedge CLK) begin
        if (rst || i_clear) begin
            r_shift   <= '0;
            r_err_cnt <= '0;
        end else if (i_shift_en) begin
            r_shift <= w_word[14:0];
            if (i_cmp_stb && (w_word != EXPECTED) && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
            end
        end
    end

    assign o_err_cnt = r_err_cnt;

endmodule

// File: rtl/reversalmb_pattern_comparator.sv
// REVERSALMB receive comparator: run FSM, beat/iteration counters and the
// registered per-lane pass/fail result.
module reversalmb_pattern_comparator
    import reversalmb_pattern_comparator_pkg::*;
#(
    parameter int unsigned NUM_LANES     = 16,
    parameter int unsigned ITERATIONS    = 128,
    parameter int unsigned ERR_THRESHOLD = 16,
    parameter int unsigned ERR_CNT_W     = 8
) (
    input  logic                            CLK,
    input  logic                            rst,
    reversalmb_pattern_comparator_if.slave  bus
);
    localparam logic [7:0] LAST_ITER = 8'(ITERATIONS - 1);

    rmb_state_e           r_state;
    rmb_state_e           w_state_next;
    logic [3:0]           r_beat;
    logic [7:0]           r_iter;
    logic [NUM_LANES-1:0] r_result;
    logic                 r_result_valid;

    logic                 w_clear;
    logic                 w_start;
    logic                 w_shift_en;
    logic                 w_cmp_stb;
    logic                 w_eval;
    logic                 w_busy;
    logic                 w_lane_clr;
    logic [NUM_LANES-1:0] w_pass;
    logic [ERR_CNT_W-1:0] w_err_cnt [NUM_LANES];

    assign w_clear = (bus.i_clear_comparator == CLEAR_CMD);

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_clear) begin
            w_state_next = bus.i_detect_en ? StCollect : StIdle;
        end else begin
            case (r_state)
                StIdle:    if (bus.i_detect_en) w_state_next = StCollect;
                StCollect: begin
                    if (!bus.i_detect_en) begin
                        w_state_next = StIdle;
                    end else if (bus.i_lane_valid && (r_beat == 4'd15) && (r_iter == LAST_ITER)) begin
                        w_state_next = StEval;
                    end
                end
                StEval:    w_state_next = StDone;
                StDone:    if (!bus.i_detect_en) w_state_next = StIdle;
                default:   w_state_next = StIdle;
            endcase
        end
    end

    // Clear overrides every strobe, so a clear on the final beat suppresses the result.
    always_comb begin
        w_start    = 1'b0;
        w_shift_en = 1'b0;
        w_cmp_stb  = 1'b0;
        w_eval     = 1'b0;
        w_busy     = (r_state == StCollect);
        if (!w_clear) begin
            case (r_state)
                StIdle:    w_start = bus.i_detect_en;
                StCollect: begin
                    w_shift_en = bus.i_detect_en && bus.i_lane_valid;
                    w_cmp_stb  = w_shift_en && (r_beat == 4'd15);
                end
                StEval:    w_eval = 1'b1;
                default:   ;
            endcase
        end
        w_lane_clr = w_clear || w_start;
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_beat         <= '0;
            r_iter         <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            if (w_lane_clr) begin
                r_beat <= '0;
                r_iter <= '0;
            end
            if (w_clear) begin
                r_result <= '0;
            end
            if (w_shift_en) begin
                r_beat <= r_beat + 4'd1;
                if (w_cmp_stb && (r_iter != 8'hFF)) begin
                    r_iter <= r_iter + 8'd1;
                end
            end
            if (w_eval) begin
                r_result       <= w_pass;
                r_result_valid <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        reversalmb_lane_err_counter #(
            .LANE_IDX  (g),
            .ERR_CNT_W (ERR_CNT_W)
        ) u_lane (
            .CLK        (CLK),
            .rst        (rst),
            .i_clear    (w_lane_clr),
            .i_shift_en (w_shift_en),
            .i_cmp_stb  (w_cmp_stb),
            .i_bit      (bus.i_lane_data[g]),
            .o_err_cnt  (w_err_cnt[g])
        );
        assign w_pass[g] = (w_err_cnt[g] <= ERR_CNT_W'(ERR_THRESHOLD));
    end

    assign bus.o_REVERSAL_Pattern_Result_logged = r_result;
    assign bus.o_result_valid                   = r_result_valid;
    assign bus.o_busy                           = w_busy;
    assign bus.o_iter_count                     = r_iter;

endmodule

// File: tb/tb_reversalmb_pattern_comparator.sv
// Bench for reversalmb_pattern_comparator: table-driven full runs against a
// word-level reference model, plus clear/abort/reset sequences.
module tb_reversalmb_pattern_comparator;

    localparam int ITER  = 128;
    localparam int LANES = 16;

    logic CLK = 1'b0;
    logic rst = 1'b1;
    always #5 CLK = ~CLK;

    reversalmb_pattern_comparator_if #(.NUM_LANES(LANES)) bus ();

    reversalmb_pattern_comparator u_dut (
        .CLK (CLK),
        .rst (rst),
        .bus (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          pulse_total = 0;
    int          pulse_base = 0;
    logic [15:0] words [ITER][LANES];

    typedef struct {
        string       name;
        int          mode;
        int          stall_pct;
        bit          junk_clr;
        bit          use_model;
        logic [15:0] exp;
    } vec_t;

    always @(negedge CLK) if (bus.o_result_valid === 1'b1) pulse_total++;

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    function automatic logic [15:0] ref_word(input int lane);
        logic [7:0] id;
        id = 8'(lane);
        return {4'hA, id, 4'hA};
    endfunction

    // Pass if the number of mismatching words is within 16.
    function automatic logic [15:0] model_result();
        logic [15:0] res;
        for (int l = 0; l < LANES; l++) begin
            int cnt;
            cnt = 0;
            for (int it = 0; it < ITER; it++) if (words[it][l] != ref_word(l)) cnt++;
            if (cnt > 255) cnt = 255;
            res[l] = (cnt <= 16);
        end
        return res;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // 0 clean, 1 threshold (lane5 x16, lane9 x17), 2 reversed lanes,
    // 3 random per-lane error rate, 4 all lanes corrupt for first 40 words
    task automatic fill_words(input int mode);
        int rates [LANES];
        for (int l = 0; l < LANES; l++) rates[l] = int'($urandom_range(30));
        for (int it = 0; it < ITER; it++) begin
            for (int l = 0; l < LANES; l++) begin
                logic [15:0] w;
                w = ref_word(l);
                case (mode)
                    1: if ((l == 5 && it < 16) || (l == 9 && it < 17)) w = w ^ 16'h0100;
                    2: w = ref_word(15 - l);
                    3: if (int'($urandom_range(99)) < rates[l])
                           w = w ^ (16'h0001 << $urandom_range(15));
                    4: if (it < 40) w = ~w;
                    default: ;
                endcase
                words[it][l] = w;
            end
        end
    endtask

    task automatic drive_beat(input logic [15:0] data, input logic [1:0] clr);
        bus.i_lane_valid       = 1'b1;
        bus.i_lane_data        = data;
        bus.i_clear_comparator = clr;
        tick();
        bus.i_lane_valid       = 1'b0;
        bus.i_clear_comparator = 2'b00;
    endtask

    function automatic logic [15:0] beat_bits(input int it, input int b);
        logic [15:0] d;
        for (int l = 0; l < LANES; l++) d[l] = words[it][l][b];
        return d;
    endfunction

    task automatic stream(input int first, input int last, input int stall_pct,
                          input bit junk, input string name);
        for (int it = first; it <= last; it++) begin
            if (it % 16 == 0) begin
                check($sformatf("%s busy@%0d", name, it), 32'(bus.o_busy), 32'd1);
                check($sformatf("%s iter@%0d", name, it), 32'(bus.o_iter_count), 32'(it));
            end
            for (int b = 15; b >= 0; b--) begin
                logic [1:0] clr;
                int n;
                n = 0;
                while (int'($urandom_range(99)) < stall_pct && n < 8) begin
                    bus.i_lane_valid = 1'b0;
                    bus.i_lane_data  = 16'($urandom);
                    tick();
                    n++;
                end
                clr = 2'b00;
                if (junk) begin
                    case ($urandom_range(2))
                        1:       clr = 2'b10;
                        2:       clr = 2'b11;
                        default: clr = 2'b00;
                    endcase
                end
                drive_beat(beat_bits(it, b), clr);
            end
        end
    endtask

    task automatic start_run();
        bus.i_detect_en  = 1'b1;
        bus.i_lane_valid = 1'b0;
        tick();
        pulse_base = pulse_total;
    endtask

    task automatic finish_and_check(input string name, input logic [15:0] exp);
        check({name, " valid_early"}, 32'(bus.o_result_valid), 32'd0);
        tick();
        check({name, " valid_lat"}, 32'(bus.o_result_valid), 32'd1);
        check({name, " result"}, 32'(bus.o_REVERSAL_Pattern_Result_logged), 32'(exp));
        check({name, " iter"}, 32'(bus.o_iter_count), 32'd128);
        check({name, " busy_done"}, 32'(bus.o_busy), 32'd0);
        bus.i_lane_valid = 1'b1;
        bus.i_lane_data  = 16'hFFFF;
        repeat (3) tick();
        check({name, " pulses"}, 32'(pulse_total - pulse_base), 32'd1);
        check({name, " held"}, 32'(bus.o_REVERSAL_Pattern_Result_logged), 32'(exp));
        bus.i_lane_valid = 1'b0;
        bus.i_detect_en  = 1'b0;
        tick();
    endtask

    task automatic run_full(input vec_t v);
        logic [15:0] required;
        fill_words(v.mode);
        required = v.use_model ? model_result() : v.exp;
        start_run();
        stream(0, ITER - 1, v.stall_pct, v.junk_clr, v.name);
        finish_and_check(v.name, required);
    endtask

    initial begin
        vec_t vecs [6];
        vecs[0] = '{"clean",     0, 0,  1'b0, 1'b0, 16'hFFFF};
        vecs[1] = '{"threshold", 1, 0,  1'b0, 1'b0, 16'hFDFF};
        vecs[2] = '{"reversal",  2, 0,  1'b0, 1'b0, 16'h0000};
        vecs[3] = '{"random_a",  3, 20, 1'b0, 1'b1, 16'h0000};
        vecs[4] = '{"random_b",  3, 0,  1'b1, 1'b1, 16'h0000};
        vecs[5] = '{"stalls",    0, 50, 1'b1, 1'b0, 16'hFFFF};

        bus.i_detect_en        = 1'b0;
        bus.i_clear_comparator = 2'b00;
        bus.i_lane_valid       = 1'b0;
        bus.i_lane_data        = '0;
        repeat (3) tick();
        check("rst result", 32'(bus.o_REVERSAL_Pattern_Result_logged), 32'd0);
        check("rst valid", 32'(bus.o_result_valid), 32'd0);
        check("rst busy", 32'(bus.o_busy), 32'd0);
        check("rst iter", 32'(bus.o_iter_count), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) run_full(vecs[i]);

        // Abort mid-run with corrupt data: result retained, next start zeroes counters.
        fill_words(4);
        start_run();
        stream(0, 19, 0, 1'b0, "abort");
        for (int b = 15; b >= 11; b--) drive_beat(beat_bits(20, b), 2'b00);
        bus.i_detect_en = 1'b0;
        tick();
        check("abort busy", 32'(bus.o_busy), 32'd0);
        check("abort result", 32'(bus.o_REVERSAL_Pattern_Result_logged), 32'hFFFF);
        check("abort pulses", 32'(pulse_total - pulse_base), 32'd0);
        tick();
        run_full('{"after_abort", 0, 0, 1'b0, 1'b0, 16'hFFFF});

        // Reset mid-COLLECT.
        fill_words(0);
        start_run();
        stream(0, 9, 0, 1'b0, "rst_mid");
        rst = 1'b1;
        bus.i_detect_en = 1'b0;
        tick();
        check("rst_mid result", 32'(bus.o_REVERSAL_Pattern_Result_logged), 32'd0);
        check("rst_mid busy", 32'(bus.o_busy), 32'd0);
        check("rst_mid iter", 32'(bus.o_iter_count), 32'd0);
        check("rst_mid valid", 32'(bus.o_result_valid), 32'd0);
        rst = 1'b0;
        tick();
        run_full('{"after_rst", 0, 0, 1'b0, 1'b0, 16'hFFFF});

        // Clear after 40 corrupt words with detect held: fresh run follows.
        fill_words(4);
        start_run();
        stream(0, 39, 0, 1'b0, "clr_mid");
        check("clr_mid iter_pre", 32'(bus.o_iter_count), 32'd40);
        bus.i_clear_comparator = 2'b01;
        tick();
        bus.i_clear_comparator = 2'b00;
        check("clr_mid iter", 32'(bus.o_iter_count), 32'd0);
        check("clr_mid result", 32'(bus.o_REVERSAL_Pattern_Result_logged), 32'd0);
        check("clr_mid busy", 32'(bus.o_busy), 32'd1);
        fill_words(0);
        stream(0, ITER - 1, 0, 1'b0, "clr_fresh");
        finish_and_check("clr_fresh", 16'hFFFF);

        // Clear coinciding with the final compare beat: no result pulse.
        fill_words(0);
        start_run();
        stream(0, ITER - 2, 0, 1'b0, "clr_last");
        for (int b = 15; b >= 1; b--) drive_beat(beat_bits(ITER - 1, b), 2'b00);
        drive_beat(beat_bits(ITER - 1, 0), 2'b01);
        check("clr_last busy", 32'(bus.o_busy), 32'd1);
        check("clr_last iter", 32'(bus.o_iter_count), 32'd0);
        check("clr_last result", 32'(bus.o_REVERSAL_Pattern_Result_logged), 32'd0);
        repeat (3) tick();
        check("clr_last pulses", 32'(pulse_total - pulse_base), 32'd0);
        check("clr_last valid", 32'(bus.o_result_valid), 32'd0);
        bus.i_detect_en = 1'b0;
        tick();
        check("clr_last idle", 32'(bus.o_busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
